sha256_block_ctrl: RTL
======================

# sha256_block_ctrl

Sequencer for one SHA-256 compression per 512-bit block. It accepts 16 message words over a valid/ready handshake and drives the K constant ROM address for 64 rounds, one round per cycle. It expands the message schedule on the fly, adds the working variables into the chaining value and presents the 256-bit digest. It sits between the message padder (upstream) and the K constant ROM; the initial hash constants H0..H7 are built in as chaining-value seeds.

## Interface
- No parameters; widths and round count are fixed by SHA-256.
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  in_word valid
- in_ready  out  1  block can accept a word
- in_word  in  32  message word, W0 first, big-endian word order
- in_first  in  1  sampled with word 0 only: 1 = new message (chain from initial constants), 0 = chain from previous digest
- k_addr  out  6  K ROM address = current round index
- k_value  in  32  K[k_addr], combinational from ROM, used same cycle
- busy  out  1  high in ROUND and FINAL
- digest_valid  out  1  one-cycle pulse, digest updated
- digest  out  256  H0 in [255:224] … H7 in [31:0]

## Operation
- States:
  - LOAD: in_ready=1; each handshake (in_valid & in_ready) writes word to schedule shift register slot cnt, cnt++; on 16th handshake -> ROUND, cnt=0; a..h loaded from chaining value (initial constants if latched in_first=1, else current H).
  - ROUND: 64 cycles, t=0..63; k_addr=t; W_t = slot 0 of 16-word shift register; T1 = h+Σ1(e)+Ch(e,f,g)+k_value+W_t, T2 = Σ0(a)+Maj(a,b,c); standard a..h update; register shifts by one, new tail = σ1(w14)+w9+σ0(w1)+w0; after t=63 -> FINAL.
  - FINAL: 1 cycle; H_i <= chain_i + {a..h}_i; digest <= new H; -> LOAD, digest_valid pulse.
- All additions modulo 2^32, carries discarded; rotates per FIPS 180-4.
- in_first is latched only on the word-0 handshake and ignored on words 1..15.
- in_valid gaps during LOAD: count held, no timeout. Words offered while in_ready=0 are ignored and not consumed.
- digest holds its value until the next FINAL; it is not cleared by a new LOAD.
- k_addr=0 outside ROUND.
- Reset mid-operation: block discarded, no digest_valid, state as after reset.

## Timing
- Reset values: state LOAD, cnt=0, in_ready=1, busy=0, digest_valid=0, digest=0, k_addr=0, H = initial constants (6a09e667 … 5be0cd19), a..h=0.
- Cycle L = 16th handshake. Round t occurs in cycle L+1+t with k_addr=t. FINAL occurs in cycle L+65.
- digest_valid=1 and new digest visible in cycle L+66. In that same cycle in_ready=1, so the next block's word 0 can be accepted.
- Block throughput: 16 load cycles (minimum) + 64 + 1 = 81 cycles.
- busy is high in cycles L+1..L+65. in_ready=0 in those same cycles.

## Test plan
- "abc", in_first=1, words 61626380, 14×00000000, 00000018 with no gaps -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, digest_valid exactly in cycle L+66, single pulse.
- Empty message: 80000000 then 15×0, in_first=1 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (block 1 in_first=1, block 2 in_first=0) -> two digest_valid pulses; final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- "abc" with random in_valid gaps, plus words driven during ROUND -> same digest as scenario 1; in_ready=0 for 65 cycles; extra words not consumed; k_addr sweeps 0..63 then 0.
- Assert rst at round 30 of "abc", release, resend "abc" -> no pulse from aborted block; correct "abc" digest.
- "abc" twice back-to-back, in_first=1 both times -> identical digests. Repeat with in_first=0 on the second block -> digest differs from the first.

Source files
------------

// File: rtl/sha256_block_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sha256_block_ctrl                                          |
// | Description : SHA-256 single-block compression sequencer. Loads 16       |
// |               message words over valid/ready, runs 64 rounds (one per    |
// |               cycle) with on-the-fly message schedule expansion, then    |
// |               folds the working variables into the chaining value and    |
// |               presents the 256-bit digest.                               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk           in   1    clock, rising edge                             |
// |   rst           in   1    asynchronous active-high reset                 |
// |   in_valid      in   1    in_word valid                                  |
// |   in_ready      out  1    block accepts a word (LOAD state)              |
// |   in_word       in   32   message word, W0 first                         |
// |   in_first      in   1    on word 0: 1 = start from initial constants    |
// |   k_addr        out  6    K ROM address (round index, 0 outside ROUND)   |
// |   k_value       in   32   K[k_addr], combinational from ROM              |
// |   busy          out  1    high in ROUND and FINAL                        |
// |   digest_valid  out  1    one-cycle pulse when digest is updated         |
// |   digest        out  256  H0 in [255:224] ... H7 in [31:0]               |
// +--------------------------------------------------------------------------+
module sha256_block_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_word,
  input  logic         in_first,
  output logic [5:0]   k_addr,
  input  logic [31:0]  k_value,
  output logic         busy,
  output logic         digest_valid,
  output logic [255:0] digest
);

  localparam logic [255:0] H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [5:0]   cnt;          // word index in LOAD, round index in ROUND
  logic         first_lat;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [31:0]  w [16];       // slot 0 always holds W_t during ROUND
  logic [255:0] hash;
  logic [255:0] chain;
  logic [255:0] hash_new;
  logic [31:0]  t1;
  logic [31:0]  t2;
  logic [31:0]  w_next;
  logic         load_last;

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Chaining source stays selected by the latched in_first for the whole
  // block, so both the a..h seed and the final feed-forward use it.
  assign chain = first_lat ? H_INIT : hash;

  assign hash_new = {chain[255:224] + a, chain[223:192] + b,
                     chain[191:160] + c, chain[159:128] + d,
                     chain[127:96]  + e, chain[95:64]   + f,
                     chain[63:32]   + g, chain[31:0]    + h};

  assign t1     = h + bsig1(e) + ((e & f) ^ (~e & g)) + k_value + w[0];
  assign t2     = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
  // Window holds W_t..W_t+15, so the new tail is W_t+16.
  assign w_next = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    k_addr    = 6'd0;
    load_last = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (cnt == 6'd15)) begin
          load_last = 1'b1;
          state_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        busy   = 1'b1;
        k_addr = cnt;
        if (cnt == 6'd63) begin
          state_nxt = S_FINAL;
        end
      end
      S_FINAL: begin
        busy      = 1'b1;
        state_nxt = S_LOAD;
      end
      default: begin
        state_nxt = S_LOAD;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= 6'd0;
      first_lat    <= 1'b0;
      a            <= 32'd0;
      b            <= 32'd0;
      c            <= 32'd0;
      d            <= 32'd0;
      e            <= 32'd0;
      f            <= 32'd0;
      g            <= 32'd0;
      h            <= 32'd0;
      for (int i = 0; i < 16; i++) begin
        w[i] <= 32'd0;
      end
      hash         <= H_INIT;
      digest       <= 256'd0;
      digest_valid <= 1'b0;
    end else begin
      digest_valid <= 1'b0;
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            w[cnt[3:0]] <= in_word;
            if (cnt == 6'd0) begin
              first_lat <= in_first;
            end
            if (load_last) begin
              cnt <= 6'd0;
              a   <= chain[255:224];
              b   <= chain[223:192];
              c   <= chain[191:160];
              d   <= chain[159:128];
              e   <= chain[127:96];
              f   <= chain[95:64];
              g   <= chain[63:32];
              h   <= chain[31:0];
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        S_ROUND: begin
          h   <= g;
          g   <= f;
          f   <= e;
          e   <= d + t1;
          d   <= c;
          c   <= b;
          b   <= a;
          a   <= t1 + t2;
          for (int i = 0; i < 15; i++) begin
            w[i] <= w[i+1];
          end
          w[15] <= w_next;
          cnt   <= cnt + 6'd1;   // wraps 63 -> 0 for the next LOAD
        end
        S_FINAL: begin
          hash         <= hash_new;
          digest       <= hash_new;
          digest_valid <= 1'b1;
        end
        default: begin
          cnt <= 6'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
